// File: rtl/cam_seq_pkg.sv
// Shared definitions for the camera power/reset sequencer: state encodings
// and the elaboration-time helpers that turn microsecond delays into cycles.
package cam_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PWR_WAIT = 3'd1,
    ST_RST_DLY  = 3'd2,
    ST_INIT     = 3'd3,
    ST_ON       = 3'd4,
    ST_SHUT     = 3'd5,
    ST_STBY     = 3'd6,
    ST_WAKE     = 3'd7
  } cam_state_t;

  // Whole cycles per microsecond times the delay; the clock is a whole number of MHz.
  function automatic int us_to_cyc(input int freq_hz, input int t_us);
    return (freq_hz / 1_000_000) * t_us;
  endfunction

  // Counter width able to hold the largest reload value, with one bit of headroom.
  function automatic int cnt_width(input int max_cyc);
    return $clog2(max_cyc) + 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cam_seq_timer.sv
// Phase timer for the sequencer: loadable down-counter that holds at zero
// and flags expiry while it reads zero.
module cam_seq_timer
  import cam_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority; otherwise count down and stop at zero.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/cam_power_seq.sv
// Camera power/reset sequencer. Walks PWDN and RESETB through a timed
// power-up, an ordered power-down (also used to abort a power-up), and,
// when CAM_PWR_SEQ_STANDBY_EN is defined, a standby/wake path driven by
// the level input stby_req. Without the macro stby_req does not exist.
module cam_power_seq
  import cam_seq_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int T_PWR_US      = 6000,
  parameter int T_PWDN_RST_US = 2000,
  parameter int T_RST_INIT_US = 20000,
  parameter int T_OFF_US      = 1000,
  parameter int T_WAKE_US     = 1000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
`ifdef CAM_PWR_SEQ_STANDBY_EN
  input  logic       stby_req,
`endif
  input  logic       seq_start,
  input  logic       seq_stop,
  output logic       cam_rstb,
  output logic       cam_pwdn,
  output logic       seq_done,
  output logic       seq_busy,
  output logic [2:0] seq_state
);

  localparam int T_PWR_CYC      = us_to_cyc(CLK_FREQ_HZ, T_PWR_US);
  localparam int T_PWDN_RST_CYC = us_to_cyc(CLK_FREQ_HZ, T_PWDN_RST_US);
  localparam int T_RST_INIT_CYC = us_to_cyc(CLK_FREQ_HZ, T_RST_INIT_US);
  localparam int T_OFF_CYC      = us_to_cyc(CLK_FREQ_HZ, T_OFF_US);
  localparam int T_WAKE_CYC     = us_to_cyc(CLK_FREQ_HZ, T_WAKE_US);
  localparam int MAX_CYC = max2(max2(max2(T_PWR_CYC, T_PWDN_RST_CYC),
                                     max2(T_RST_INIT_CYC, T_OFF_CYC)), T_WAKE_CYC);
  localparam int CNT_W = cnt_width(MAX_CYC);

  localparam logic [CNT_W-1:0] LD_PWR      = CNT_W'(T_PWR_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PWDN_RST = CNT_W'(T_PWDN_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LD_RST_INIT = CNT_W'(T_RST_INIT_CYC - 1);
  localparam logic [CNT_W-1:0] LD_OFF      = CNT_W'(T_OFF_CYC - 1);
`ifdef CAM_PWR_SEQ_STANDBY_EN
  localparam logic [CNT_W-1:0] LD_WAKE     = CNT_W'(T_WAKE_CYC - 1);
`endif

  // A zero-length phase or a fractional-MHz clock cannot be timed correctly.
  if ((CLK_FREQ_HZ % 1_000_000) != 0 || CLK_FREQ_HZ < 1_000_000) begin : g_bad_freq
    $error("cam_power_seq: CLK_FREQ_HZ must be a non-zero multiple of 1 MHz");
  end
  if (T_PWR_CYC < 1 || T_PWDN_RST_CYC < 1 || T_RST_INIT_CYC < 1 ||
      T_OFF_CYC < 1 || T_WAKE_CYC < 1) begin : g_bad_delay
    $error("cam_power_seq: every phase delay must be at least one cycle");
  end

  cam_state_t       state, state_nxt;
  logic             rstb_nxt, pwdn_nxt, done_nxt, busy_nxt;
  logic             go_shut;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_expired;

  cam_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .load       (tmr_load),
    .load_value (tmr_val),
    .dec        (1'b1),
    .expired    (tmr_expired)
  );

  // Next state, next pin levels and timer reload; stop beats start and expiry.
  always_comb begin
    state_nxt = state;
    rstb_nxt  = cam_rstb;
    pwdn_nxt  = cam_pwdn;
    done_nxt  = seq_done;
    go_shut   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      ST_OFF: begin
        if (seq_start && !seq_stop) begin
          state_nxt = ST_PWR_WAIT;
          tmr_load  = 1'b1;
          tmr_val   = LD_PWR;
        end
      end
      ST_PWR_WAIT: begin
        if (seq_stop) begin
          go_shut = 1'b1;
        end else if (tmr_expired) begin
          pwdn_nxt  = 1'b0;
          state_nxt = ST_RST_DLY;
          tmr_load  = 1'b1;
          tmr_val   = LD_PWDN_RST;
        end
      end
      ST_RST_DLY: begin
        if (seq_stop) begin
          go_shut = 1'b1;
        end else if (tmr_expired) begin
          rstb_nxt  = 1'b1;
          state_nxt = ST_INIT;
          tmr_load  = 1'b1;
          tmr_val   = LD_RST_INIT;
        end
      end
      ST_INIT: begin
        if (seq_stop) begin
          go_shut = 1'b1;
        end else if (tmr_expired) begin
          done_nxt  = 1'b1;
          state_nxt = ST_ON;
        end
      end
      ST_ON: begin
        if (seq_stop) begin
          go_shut = 1'b1;
`ifdef CAM_PWR_SEQ_STANDBY_EN
        end else if (stby_req) begin
          pwdn_nxt  = 1'b1;
          done_nxt  = 1'b0;
          state_nxt = ST_STBY;
`endif
        end
      end
      ST_SHUT: begin
        if (tmr_expired) begin
          pwdn_nxt  = 1'b1;
          state_nxt = ST_OFF;
        end
      end
`ifdef CAM_PWR_SEQ_STANDBY_EN
      ST_STBY: begin
        if (seq_stop) begin
          go_shut = 1'b1;
        end else if (!stby_req) begin
          pwdn_nxt  = 1'b0;
          state_nxt = ST_WAKE;
          tmr_load  = 1'b1;
          tmr_val   = LD_WAKE;
        end
      end
      ST_WAKE: begin
        if (seq_stop) begin
          go_shut = 1'b1;
        end else if (tmr_expired) begin
          done_nxt  = 1'b1;
          state_nxt = ST_ON;
        end
      end
`endif
      default: begin
        state_nxt = ST_OFF;
      end
    endcase
    // Shutdown always drops RESETB first; PWDN follows when SHUT expires.
    if (go_shut) begin
      rstb_nxt  = 1'b0;
      done_nxt  = 1'b0;
      state_nxt = ST_SHUT;
      tmr_load  = 1'b1;
      tmr_val   = LD_OFF;
    end
    busy_nxt = (state_nxt == ST_PWR_WAIT) || (state_nxt == ST_RST_DLY) ||
               (state_nxt == ST_INIT) || (state_nxt == ST_SHUT) ||
               (state_nxt == ST_WAKE);
  end

  // State and pin registers; reset parks the sensor powered down and in reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= ST_OFF;
      cam_rstb <= 1'b0;
      cam_pwdn <= 1'b1;
      seq_done <= 1'b0;
      seq_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      cam_rstb <= rstb_nxt;
      cam_pwdn <= pwdn_nxt;
      seq_done <= done_nxt;
      seq_busy <= busy_nxt;
    end
  end

  assign seq_state = state;

endmodule
